// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM, ALU/immediate decode, retire counter, illegal-opcode halt
// Build option: define CTRL_BNE_EN to accept bne (branch funct3 001) in addition to beq.
// Ports:
//   clk, rst (async active-low)     clock and reset
//   Instr[31:0], zero               latched IR and ALU zero flag from the datapath
//   ImmSrc, ALUControl              immediate type and ALU operation (decoded from Instr)
//   ResultSrc, ALUSrcA, ALUSrcB     datapath mux selects
//   AddrSrc                         memory address select (0 PC, 1 Result)
//   IRWrite, PCWrite, RegWrite,
//   MemWrite                        write enables
//   instret[CNT_W-1:0]              retired-instruction count
//   halted                          illegal instruction seen, core stopped
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instr,
    input  logic             zero,
    output logic [1:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             AddrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              f7b5, f3_ok, br_ok, br_take, retire;
    logic [3:0]        alu_dec;
    logic              unused_instr;

    assign op           = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign f7b5         = Instr[30];
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};
    assign f3_ok        = funct3 != 3'b011;

`ifdef CTRL_BNE_EN
    assign br_ok   = funct3 == 3'b000 || funct3 == 3'b001;
    assign br_take = funct3[0] ? ~zero : zero;
`else
    assign br_ok   = funct3 == 3'b000;
    assign br_take = zero;
`endif

    // funct7[5] selects sub only for R-type; I-type shifts have no arithmetic variant here
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (op == OP_R && f7b5) ? 4'b0001 : 4'b0000;
            3'b111:  alu_dec = 4'b0010;
            3'b110:  alu_dec = 4'b0011;
            3'b100:  alu_dec = 4'b0100;
            3'b010:  alu_dec = 4'b0101;
            3'b001:  alu_dec = 4'b0110;
            3'b101:  alu_dec = 4'b0111;
            default: alu_dec = 4'b0000;
        endcase
    end

    assign ALUControl = (state_q == EXECR || state_q == EXECI) ? alu_dec :
                        state_q == BEQ ? 4'b0001 : 4'b0000;
    assign ImmSrc     = op == OP_SW ? 2'b01 : op == OP_BR ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    assign retire     = state_q == MEMWB || state_q == MEMWRITE || state_q == ALUWB || state_q == BEQ;
    assign instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
    assign instret    = instret_q;
    assign halted     = state_q == HALT;

    always_comb begin
        state_d   = state_q;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        AddrSrc   = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            FETCH: begin
                // reset parks the FSM here, so only these enables need gating by rst
                IRWrite   = rst;
                PCWrite   = rst;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = f3_ok ? EXECR : HALT;
                    OP_I:         state_d = f3_ok ? EXECI : HALT;
                    OP_BR:        state_d = br_ok ? BEQ : HALT;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op == OP_LW ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AddrSrc = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AddrSrc  = 1'b1;
                MemWrite = 1'b1;
                state_d  = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                PCWrite = br_take;
                state_d = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller (CNT_W=4)
module tb_mc_controller;
    typedef struct packed {
        logic       ir, pcw, rw, mw, addr;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
        logic [1:0] imm;
        logic       halt;
        logic [3:0] cnt;
    } obs_t;
    typedef struct packed {obs_t v; obs_t m;} exp_t;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, XR = 6, XI = 7;
    localparam int AWB = 8, B = 9, H = 11, R = 12;
    localparam int P_I = 0, P_R = 1, P_LW = 2, P_SW = 3, P_BR = 4, P_H = 5;

    logic        clk = 1'b0, rst = 1'b0, zero = 1'b0;
    logic [31:0] Instr = 32'h0000_0013;
    logic [1:0]  ImmSrc, ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl, instret;
    logic        AddrSrc, IRWrite, PCWrite, RegWrite, MemWrite, halted;
    obs_t        o;
    exp_t        q[$];
    logic [3:0]  cnt = 4'd0;
    int          checks = 0, failures = 0, cyc = 0;
    string       tag = "reset";

    mc_controller #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .zero(zero),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AddrSrc(AddrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .instret(instret), .halted(halted)
    );

    always #5 clk = ~clk;

    assign o = {IRWrite, PCWrite, RegWrite, MemWrite, AddrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, halted, instret};

    task automatic push(input int s, input logic [3:0] alu, input logic pcw,
                        input logic [1:0] imm, input bit ic);
        exp_t e;
        e = '0;
        {e.m.ir, e.m.pcw, e.m.rw, e.m.mw, e.m.halt} = '1;
        e.m.cnt = '1;
        e.v.cnt = cnt;
        if (ic && s != F && s != R && s != H) begin
            e.m.imm = '1;
            e.v.imm = imm;
        end
        case (s)
            F, R: begin
                e.v.ir = s == F; e.v.pcw = s == F;
                e.m.addr = 1'b1; e.m.rs = '1; e.v.rs = 2'b10;
                e.m.sa = '1; e.m.sb = '1; e.v.sb = 2'b10; e.m.alu = '1;
            end
            D:   begin e.m.sa = '1; e.v.sa = 2'b01; e.m.sb = '1; e.v.sb = 2'b01; e.m.alu = '1; end
            MA:  begin e.m.sa = '1; e.v.sa = 2'b10; e.m.sb = '1; e.v.sb = 2'b01; e.m.alu = '1; end
            MR:  begin e.m.rs = '1; e.m.addr = 1'b1; e.v.addr = 1'b1; end
            MWB: begin e.m.rs = '1; e.v.rs = 2'b01; e.v.rw = 1'b1; end
            MW:  begin e.m.rs = '1; e.m.addr = 1'b1; e.v.addr = 1'b1; e.v.mw = 1'b1; end
            XR:  begin e.m.sa = '1; e.v.sa = 2'b10; e.m.sb = '1; e.m.alu = '1; e.v.alu = alu; end
            XI:  begin e.m.sa = '1; e.v.sa = 2'b10; e.m.sb = '1; e.v.sb = 2'b01; e.m.alu = '1; e.v.alu = alu; end
            AWB: begin e.m.rs = '1; e.v.rw = 1'b1; end
            B:   begin
                e.m.sa = '1; e.v.sa = 2'b10; e.m.sb = '1; e.m.alu = '1; e.v.alu = 4'b0001;
                e.m.rs = '1; e.v.pcw = pcw;
            end
            H:   e.v.halt = 1'b1;
            default: ;
        endcase
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        cyc = 0;
        while (q.size() > 0) begin
            #1;
            e = q.pop_front();
            cyc++;
            checks++;
            assert ((o & e.m) === e.v) else begin
                failures++;
                $error("FAIL %s cyc%0d observed=%h expected=%h mask=%h", tag, cyc, o & e.m, e.v, e.m);
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_seq(input int n);
        tag = "reset";
        rst = 1'b0;
        cnt = 4'd0;
        for (int i = 0; i < n; i++) push(R, 4'h0, 1'b0, 2'b00, 1'b0);
        drain();
        rst = 1'b1;
    endtask

    task automatic run(input string name, input logic [31:0] ins, input logic z,
                       input logic [1:0] imm, input bit ic, input logic [3:0] alu, input int path);
        tag = name;
        Instr = ins;
        zero = z;
        push(F, 4'h0, 1'b0, imm, ic);
        push(D, 4'h0, 1'b0, imm, ic);
        case (path)
            P_I:  begin push(XI, alu, 1'b0, imm, ic); push(AWB, 4'h0, 1'b0, imm, ic); end
            P_R:  begin push(XR, alu, 1'b0, imm, ic); push(AWB, 4'h0, 1'b0, imm, ic); end
            P_LW: begin
                push(MA, 4'h0, 1'b0, imm, ic); push(MR, 4'h0, 1'b0, imm, ic);
                push(MWB, 4'h0, 1'b0, imm, ic);
            end
            P_SW: begin push(MA, 4'h0, 1'b0, imm, ic); push(MW, 4'h0, 1'b0, imm, ic); end
            P_BR: push(B, 4'h0, alu[0], imm, ic);
            default: for (int i = 0; i < 4; i++) push(H, 4'h0, 1'b0, imm, ic);
        endcase
        drain();
        if (path != P_H) cnt = cnt + 4'd1;
    endtask

    initial begin
        @(negedge clk);
        reset_seq(3);
        run("addi",   32'h00A00093, 1'b0, 2'b00, 1'b1, 4'h0, P_I);
        run("sub",    32'h40208133, 1'b0, 2'b00, 1'b0, 4'h1, P_R);
        run("lw",     32'h0000A183, 1'b0, 2'b00, 1'b1, 4'h0, P_LW);
        run("beq_t",  32'h00000063, 1'b1, 2'b10, 1'b1, 4'h1, P_BR);
        run("beq_n",  32'h00000063, 1'b0, 2'b10, 1'b1, 4'h0, P_BR);
        run("or",     32'h0020E1B3, 1'b0, 2'b00, 1'b0, 4'h3, P_R);
        run("xori",   32'h0010C093, 1'b0, 2'b00, 1'b1, 4'h4, P_I);
        run("andi",   32'h0010F093, 1'b0, 2'b00, 1'b1, 4'h2, P_I);
        run("slti",   32'h00A0A093, 1'b0, 2'b00, 1'b1, 4'h5, P_I);
        run("slli",   32'h00109093, 1'b0, 2'b00, 1'b1, 4'h6, P_I);
        run("srli",   32'h0010D093, 1'b0, 2'b00, 1'b1, 4'h7, P_I);
        run("add",    32'h002081B3, 1'b0, 2'b00, 1'b0, 4'h0, P_R);
        for (int i = 0; i < 5; i++) run("sw", 32'h0020A023, 1'b0, 2'b01, 1'b1, 4'h0, P_SW);
        tag = "wrap";
        checks++;
        assert (instret === 4'd1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, instret, 1);
        end
`ifdef CTRL_BNE_EN
        run("bne",    32'h00001063, 1'b0, 2'b10, 1'b1, 4'h1, P_BR);
`else
        run("bne",    32'h00001063, 1'b0, 2'b10, 1'b1, 4'h0, P_H);
`endif
        reset_seq(2);
        run("illegal", 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 4'h0, P_H);
        reset_seq(2);
        run("addi2",  32'h00A00093, 1'b0, 2'b00, 1'b1, 4'h0, P_I);
        tag = "abort";
        Instr = 32'h0020A023;
        push(F, 4'h0, 1'b0, 2'b01, 1'b1);
        push(D, 4'h0, 1'b0, 2'b01, 1'b1);
        push(MA, 4'h0, 1'b0, 2'b01, 1'b1);
        drain();
        reset_seq(2);
        run("sltu",   32'h0020B1B3, 1'b0, 2'b00, 1'b0, 4'h0, P_H);
        reset_seq(1);
        run("addi3",  32'h00A00093, 1'b0, 2'b00, 1'b1, 4'h0, P_I);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
